// File: rtl/jet_tag_pkg.sv
// ---------------------------------------------------------------------------
// jet_tag_pkg
// Shared constants and types for the jet-tagging classification stage.
// The logit format matches the dense_4 output layer: WIDTH-bit two's
// complement with NFRAC fractional bits (Q6.7 by default).
//
// Optional feature macro used by the importing modules: TOP2_MARGIN_EN
// (runner-up tracking and max-minus-runner-up margin output).
// ---------------------------------------------------------------------------
package jet_tag_pkg;

   // Number of logits per vector (dense_4 output count).
   localparam int N_CLASSES = 5;

   // Logit bit width, two's complement.
   localparam int WIDTH = 14;

   // Fractional bits; documents the number format only, no arithmetic uses it.
   localparam int NFRAC = 7;

   // Class index width.
   localparam int IDX_W = $clog2(N_CLASSES);

   typedef logic signed [WIDTH-1:0] logit_t;
   typedef logic [IDX_W-1:0]        class_idx_t;

   // Most negative representable logit; seeds the runner-up so the first
   // non-winning candidate always displaces it unless it is itself the minimum.
   localparam logit_t LOGIT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Index of the final candidate examined during a scan.
   localparam class_idx_t LAST_IDX = class_idx_t'(N_CLASSES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : jet_tag_pkg

// File: rtl/argmax_cmp_sel.sv
// ---------------------------------------------------------------------------
// argmax_cmp_sel
// Combinational compare/select step of the sequential argmax scan. Compares
// one candidate logit against the current best (signed, strict greater-than
// so the lowest index wins ties) and returns the next best value/index.
//
// Optional feature macro: TOP2_MARGIN_EN. When defined the runner-up value
// and index are also tracked: a new maximum demotes the old best into the
// runner-up slot, otherwise a candidate strictly above the runner-up (which
// includes one equal to the best) becomes the new runner-up.
//
// Ports:
//   cand            in   candidate logit
//   cand_idx        in   candidate class index
//   best            in   current maximum
//   best_idx        in   index of current maximum
//   next_best       out  maximum after considering the candidate
//   next_best_idx   out  index of that maximum
//   second          in   current runner-up            (TOP2_MARGIN_EN)
//   second_idx      in   index of current runner-up   (TOP2_MARGIN_EN)
//   next_second     out  runner-up after candidate    (TOP2_MARGIN_EN)
//   next_second_idx out  index of that runner-up      (TOP2_MARGIN_EN)
// ---------------------------------------------------------------------------
module argmax_cmp_sel
   import jet_tag_pkg::*;
(
   input  logit_t     cand,
   input  class_idx_t cand_idx,
   input  logit_t     best,
   input  class_idx_t best_idx,
   output logit_t     next_best,
   output class_idx_t next_best_idx
`ifdef TOP2_MARGIN_EN
   ,
   input  logit_t     second,
   input  class_idx_t second_idx,
   output logit_t     next_second,
   output class_idx_t next_second_idx
`endif
);

   // logit_t is signed, so the relational operators below compare signed.
   always_comb begin
      next_best     = best;
      next_best_idx = best_idx;
`ifdef TOP2_MARGIN_EN
      next_second     = second;
      next_second_idx = second_idx;
`endif
      if (cand > best) begin
         next_best     = cand;
         next_best_idx = cand_idx;
`ifdef TOP2_MARGIN_EN
         next_second     = best;
         next_second_idx = best_idx;
`endif
      end
`ifdef TOP2_MARGIN_EN
      else if (cand > second) begin
         next_second     = cand;
         next_second_idx = cand_idx;
      end
`endif
   end

endmodule : argmax_cmp_sel

// File: rtl/jet_class_argmax.sv
// ---------------------------------------------------------------------------
// jet_class_argmax
// Classification stage after the dense_4 layer of the jet-tagging network.
// Captures one vector of N_CLASSES signed logits, scans it one comparison per
// cycle and presents the winning class index and logit over valid/ready.
// A new vector is accepted only in IDLE; there is no overlap between vectors.
//
// Timeline: the accept edge loads logit[0] as the running best, then one
// SCAN cycle per remaining logit; the result registers are loaded on the
// final SCAN edge, so out_valid is high N_CLASSES cycles after the accept
// cycle and the next vector can be taken N_CLASSES+1 cycles after the last.
//
// Optional feature macro: TOP2_MARGIN_EN adds runner-up tracking and the
// out_second_class / out_margin ports. Without it those ports and the
// runner-up registers do not exist.
//
// Ports:
//   clk              in   clock
//   rst_n            in   asynchronous active-low reset
//   in_valid         in   logit vector valid
//   in_ready         out  block can accept a vector
//   in_logits        in   packed logits, class k at [k*WIDTH +: WIDTH]
//   out_valid        out  result valid
//   out_ready        in   consumer accepts the result
//   out_class        out  index of the maximum logit
//   out_logit        out  maximum logit value
//   out_second_class out  runner-up index               (TOP2_MARGIN_EN)
//   out_margin       out  unsigned max minus runner-up   (TOP2_MARGIN_EN)
// ---------------------------------------------------------------------------
module jet_class_argmax
   import jet_tag_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_CLASSES*WIDTH-1:0]   in_logits,
   output logic                         out_valid,
   input  logic                         out_ready,
   output class_idx_t                   out_class,
   output logit_t                       out_logit
`ifdef TOP2_MARGIN_EN
   ,
   output class_idx_t                   out_second_class,
   output logic [WIDTH:0]               out_margin
`endif
);

   state_t     state;
   state_t     next_state;

   logit_t     logits [N_CLASSES];
   logit_t     best;
   class_idx_t best_idx;
   class_idx_t idx;

   logit_t     cand;
   logit_t     next_best;
   class_idx_t next_best_idx;

`ifdef TOP2_MARGIN_EN
   logit_t     second;
   class_idx_t second_idx;
   logit_t     next_second;
   class_idx_t next_second_idx;
`endif

   logic       accept;
   logic       handshake;

   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign cand      = logits[idx];

   argmax_cmp_sel u_cmp_sel (
      .cand            (cand),
      .cand_idx        (idx),
      .best            (best),
      .best_idx        (best_idx),
      .next_best       (next_best),
      .next_best_idx   (next_best_idx)
`ifdef TOP2_MARGIN_EN
      ,
      .second          (second),
      .second_idx      (second_idx),
      .next_second     (next_second),
      .next_second_idx (next_second_idx)
`endif
   );

   // Next-state logic: IDLE waits for a vector, SCAN walks indices 1..N-1,
   // DONE holds the result until the consumer takes it.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept)          next_state = ST_SCAN;
         ST_SCAN: if (idx == LAST_IDX) next_state = ST_DONE;
         ST_DONE: if (handshake)       next_state = ST_IDLE;
         default:                      next_state = ST_IDLE;
      endcase
   end

   // in_ready is registered from next_state so it is low while reset is held
   // and rises on the first edge after release; afterwards it equals
   // (state == IDLE).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         in_ready <= 1'b0;
      end else begin
         state    <= next_state;
         in_ready <= (next_state == ST_IDLE);
      end
   end

   // Datapath: capture the vector on accept, fold one candidate per SCAN
   // cycle, and load the result registers on the last compare so they are
   // already stable when out_valid rises. Reset discards any scan in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_CLASSES; k++) begin
            logits[k] <= '0;
         end
         best      <= '0;
         best_idx  <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         out_logit <= '0;
`ifdef TOP2_MARGIN_EN
         second           <= '0;
         second_idx       <= '0;
         out_second_class <= '0;
         out_margin       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  for (int k = 0; k < N_CLASSES; k++) begin
                     logits[k] <= logit_t'(in_logits[k*WIDTH +: WIDTH]);
                  end
                  best     <= logit_t'(in_logits[0 +: WIDTH]);
                  best_idx <= '0;
                  idx      <= class_idx_t'(1);
`ifdef TOP2_MARGIN_EN
                  second     <= LOGIT_MIN;
                  second_idx <= '0;
`endif
               end
            end
            ST_SCAN: begin
               best     <= next_best;
               best_idx <= next_best_idx;
               idx      <= idx + class_idx_t'(1);
`ifdef TOP2_MARGIN_EN
               second     <= next_second;
               second_idx <= next_second_idx;
`endif
               if (idx == LAST_IDX) begin
                  out_valid <= 1'b1;
                  out_class <= next_best_idx;
                  out_logit <= next_best;
`ifdef TOP2_MARGIN_EN
                  // One extra bit: the full span +8191 - (-8192) must fit.
                  out_second_class <= next_second_idx;
                  out_margin       <= {next_best[WIDTH-1], next_best}
                                    - {next_second[WIDTH-1], next_second};
`endif
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : jet_class_argmax

// File: tb/tb_jet_class_argmax.sv
// ---------------------------------------------------------------------------
// tb_jet_class_argmax
// Self-checking bench for jet_class_argmax. Expected results come from a
// small reference model evaluated when each vector is driven and are queued
// in a scoreboard; they are popped and compared when the DUT presents a
// result. Build with +define+TOP2_MARGIN_EN to also check the runner-up
// index and margin.
// ---------------------------------------------------------------------------
module tb_jet_class_argmax;
   import jet_tag_pkg::*;

   typedef struct {
      int cls;
      int logit;
      int second;
      int margin;
   } exp_t;

   logic                       clk;
   logic                       rst_n;
   logic                       in_valid;
   logic                       in_ready;
   logic [N_CLASSES*WIDTH-1:0] in_logits;
   logic                       out_valid;
   logic                       out_ready;
   class_idx_t                 out_class;
   logit_t                     out_logit;
`ifdef TOP2_MARGIN_EN
   class_idx_t                 out_second_class;
   logic [WIDTH:0]             out_margin;
`endif

   int   checks;
   int   errors;
   int   cycle_cnt;
   int   accept_cycle;
   exp_t sb [$];
   exp_t held;
   int   prev_accept;

   jet_class_argmax dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_logits        (in_logits),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_class        (out_class),
      .out_logit        (out_logit)
`ifdef TOP2_MARGIN_EN
      ,
      .out_second_class (out_second_class),
      .out_margin       (out_margin)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [N_CLASSES*WIDTH-1:0] pack5(input int a0, input int a1,
                                                        input int a2, input int a3,
                                                        input int a4);
      logic [N_CLASSES*WIDTH-1:0] r;
      int t [5];
      t = '{a0, a1, a2, a3, a4};
      r = '0;
      for (int k = 0; k < 5; k++) r[k*WIDTH +: WIDTH] = t[k][WIDTH-1:0];
      return r;
   endfunction

   // Reference: global argmax (first index on ties), then the runner-up as
   // the strict maximum over the other indices seeded with (minimum, idx 0).
   function automatic exp_t model(input logic [N_CLASSES*WIDTH-1:0] v);
      exp_t e;
      int val [N_CLASSES];
      logic signed [WIDTH-1:0] s;
      int bi, si, sv;
      for (int k = 0; k < N_CLASSES; k++) begin
         s = v[k*WIDTH +: WIDTH];
         val[k] = int'(s);
      end
      bi = 0;
      for (int k = 1; k < N_CLASSES; k++) if (val[k] > val[bi]) bi = k;
      si = 0;
      sv = -(1 << (WIDTH-1));
      for (int k = 0; k < N_CLASSES; k++) begin
         if (k != bi && val[k] > sv) begin
            si = k;
            sv = val[k];
         end
      end
      e.cls    = bi;
      e.logit  = val[bi];
      e.second = si;
      e.margin = val[bi] - sv;
      return e;
   endfunction

   task automatic check_output(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fail_timeout(input string tag);
      checks++;
      errors++;
      $display("[TB] FAIL %s: observed timeout expected event", tag);
   endtask

   // Called just after a negedge. Drives the vector, waits (bounded) for
   // in_ready, queues the expected result and lets the accept edge pass.
   task automatic send_vector(input logic [N_CLASSES*WIDTH-1:0] v, input bit keep_valid);
      int n;
      logic [95:0] junk;
      in_valid  = 1'b1;
      in_logits = v;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_timeout("accept");
         in_valid = 1'b0;
         return;
      end
      sb.push_back(model(v));
      accept_cycle = cycle_cnt;
      @(negedge clk);
      if (!keep_valid) in_valid = 1'b0;
      junk = {$urandom(), $urandom(), $urandom()};
      in_logits = junk[N_CLASSES*WIDTH-1:0];
   endtask

   task automatic wait_result(input string tag, input bit check_lat, output exp_t e);
      int n;
      n = 0;
      e = '{0, 0, 0, 0};
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         fail_timeout({tag, "_valid"});
         return;
      end
      if (sb.size() == 0) begin
         fail_timeout({tag, "_unexpected"});
         return;
      end
      e = sb.pop_front();
      if (check_lat) check_output({tag, "_latency"}, cycle_cnt - accept_cycle, N_CLASSES);
      check_output({tag, "_class"}, {29'd0, out_class}, e.cls);
      check_output({tag, "_logit"}, 32'($signed(out_logit)), e.logit);
`ifdef TOP2_MARGIN_EN
      check_output({tag, "_second"}, {29'd0, out_second_class}, e.second);
      check_output({tag, "_margin"}, {17'd0, out_margin}, e.margin);
`endif
   endtask

   initial begin
      exp_t e;
      checks      = 0;
      errors      = 0;
      cycle_cnt   = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_logits   = '0;
      out_ready   = 1'b1;
      prev_accept = 0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_output("rst_out_valid", {31'd0, out_valid}, 0);
      check_output("rst_out_class", {29'd0, out_class}, 0);
      check_output("rst_out_logit", 32'($signed(out_logit)), 0);
      check_output("rst_in_ready", {31'd0, in_ready}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("post_rst_in_ready", {31'd0, in_ready}, 1);

      // Directed vectors with out_ready held high.
      send_vector(pack5(-8, -9, -9, 10, 27), 1'b0);
      wait_result("basic", 1'b1, e);
      @(negedge clk);
      send_vector(pack5(5, 5, 5, 5, 5), 1'b0);
      wait_result("ties", 1'b1, e);
      @(negedge clk);
      send_vector(pack5(-8192, -8192, -8192, -8192, 8191), 1'b0);
      wait_result("extreme", 1'b1, e);
      @(negedge clk);
      send_vector(pack5(-8192, -8192, -8192, -8192, -8192), 1'b0);
      wait_result("all_min", 1'b1, e);
      @(negedge clk);
      send_vector(pack5(100, -5, 100, -200, 99), 1'b0);
      wait_result("tie_first", 1'b1, e);
      @(negedge clk);
      send_vector(pack5(-300, 12, 8191, 8190, -1), 1'b0);
      wait_result("mid_max", 1'b1, e);
      @(negedge clk);

      // Back-pressure: hold out_ready low for 20 cycles in DONE while the
      // input side toggles randomly.
      out_ready = 1'b0;
      send_vector(pack5(3, -40, 77, 76, 0), 1'b0);
      wait_result("hold", 1'b1, held);
      for (int c = 0; c < 20; c++) begin
         logic [95:0] r;
         r = {$urandom(), $urandom(), $urandom()};
         in_valid  = r[95];
         in_logits = r[N_CLASSES*WIDTH-1:0];
         @(negedge clk);
         check_output("hold_valid", {31'd0, out_valid}, 1);
         check_output("hold_class", {29'd0, out_class}, held.cls);
         check_output("hold_logit", 32'($signed(out_logit)), held.logit);
         check_output("hold_in_ready", {31'd0, in_ready}, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_output("release_valid", {31'd0, out_valid}, 0);
      check_output("release_in_ready", {31'd0, in_ready}, 1);

      // Back-to-back: in_valid stays high, one accept every N_CLASSES+1 cycles.
      send_vector(pack5(3, 1, 2, 0, -1), 1'b1);
      prev_accept = accept_cycle;
      wait_result("b2b0", 1'b1, e);
      send_vector(pack5(0, 0, 9, 0, 0), 1'b1);
      check_output("b2b_interval1", accept_cycle - prev_accept, N_CLASSES + 1);
      prev_accept = accept_cycle;
      wait_result("b2b1", 1'b1, e);
      send_vector(pack5(-5, -4, -3, -2, -1), 1'b0);
      check_output("b2b_interval2", accept_cycle - prev_accept, N_CLASSES + 1);
      wait_result("b2b2", 1'b1, e);
      @(negedge clk);

      // Reset two cycles after accept aborts the scan with no output.
      send_vector(pack5(7, 7, 7, 7, 7), 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check_output("abort_out_valid", {31'd0, out_valid}, 0);
      check_output("abort_out_class", {29'd0, out_class}, 0);
      check_output("abort_out_logit", 32'($signed(out_logit)), 0);
      check_output("abort_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("abort_ready_back", {31'd0, in_ready}, 1);
      check_output("abort_no_stale", {31'd0, out_valid}, 0);
      send_vector(pack5(1, 2, 3, 4, 5), 1'b0);
      wait_result("after_abort", 1'b1, e);
      repeat (8) @(negedge clk);
      check_output("final_out_valid", {31'd0, out_valid}, 0);
      check_output("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_jet_class_argmax

// File: doc/jet_class_argmax.md
Name: jet_class_argmax

Overview:
- Classification stage directly downstream of the dense_4 output layer of the jet-tagging network.
- Accepts one vector of N_CLASSES signed fixed-point logits per transaction (14-bit, 7 fractional bits, matching dense_4).
- Scans the vector sequentially, one comparison per cycle, and returns the winning class index and its logit over a valid/ready handshake.

Parameters:
- N_CLASSES, 5, number of logits per vector (dense_4 output count).
- WIDTH, 14, logit bit width, two's complement.
- NFRAC, 7, fractional bits; informational only, no arithmetic depends on it.
- IDX_W, $clog2(N_CLASSES), class index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  logit vector valid.
- in_ready  out  1  block can accept a vector.
- in_logits  in  N_CLASSES*WIDTH  packed signed logits; class k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  IDX_W  index of the maximum logit.
- out_logit  out  WIDTH  signed maximum logit value.
- out_second_class  out  IDX_W  runner-up index; present only with TOP2_MARGIN_EN.
- out_margin  out  WIDTH+1  unsigned max minus runner-up; present only with TOP2_MARGIN_EN.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; in_ready=1 after reset releases.
  - out_valid, out_class, out_logit, out_second_class and out_margin are all 0.
  - Any captured vector is discarded; reset mid-scan or mid-DONE aborts with no output.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register all logits and set best=logit[0], best_idx=0, idx=1.
  - Go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle compare logit[idx] against best with a signed comparison; strict greater-than replaces best/best_idx.
  - idx increments by 1.
  - After the compare at idx=N_CLASSES-1, go to DONE.
- DONE:
  - out_valid=1; out_* registered and stable.
  - Outputs hold unchanged while out_ready=0 (back-pressure of unlimited duration).
  - On out_valid&&out_ready, go to IDLE; out_valid=0 in the next cycle.
- Latency: out_valid rises N_CLASSES cycles after the accept edge (5 by default).
- Throughput: one vector per N_CLASSES+1 cycles minimum. No overlap; in_ready=0 in SCAN and DONE.
- Ties: the lowest index wins, because replacement requires strictly greater.
- Extremes: comparisons are signed and must be correct at -8192 and +8191. No saturation is needed since nothing is added.
- in_logits is ignored outside the accept cycle.

Optional Feature:
- Macro: TOP2_MARGIN_EN.
- Defined:
  - Track the runner-up value second, initialised to -2^(WIDTH-1) with second_idx=0.
  - In SCAN, a new max moves the old best into second.
  - Otherwise, logit[idx] > second updates second; equality with best counts as runner-up (margin 0).
  - out_margin = best - second, computed at WIDTH+1 bits, always >= 0, registered on the DONE entry.
  - Latency and handshake are unchanged.
- Undefined:
  - out_second_class and out_margin ports are absent.
  - No runner-up registers exist.

Decomposition:
- Package jet_tag_pkg holds:
  - N_CLASSES, WIDTH, NFRAC;
  - typedef logit_t (logic signed [WIDTH-1:0]);
  - typedef class_idx_t;
  - the state enum.
- One natural sub-module, argmax_cmp_sel: combinational compare/select of candidate vs. current best (and runner-up when enabled), returning next best/idx.

Test Plan:
- Logits {-8,-9,-9,10,27} (Q6.7 raw) -> out_class=4, out_logit=27, out_valid 5 cycles after accept; with TOP2_MARGIN_EN, second_class=3, margin=17.
- All logits equal 5 -> out_class=0, out_logit=5; with TOP2_MARGIN_EN, second_class=1, margin=0.
- Logits {-8192,-8192,-8192,-8192,8191} -> out_class=4, out_logit=8191; margin=16383 (needs the WIDTH+1 width).
- Hold out_ready=0 for 20 cycles in DONE, toggling in_valid and in_logits -> outputs stable, in_ready=0; release -> in_ready=1 the next cycle.
- Deassert rst_n during SCAN (2 cycles after accept) -> all outputs 0 immediately; after release, a new vector {1,2,3,4,5} -> out_class=4 with no stale result.
- Back-to-back in_valid held high with out_ready=1 -> one accept every 6 cycles; results in order.
